fir_mem_host: RTL and testbench

//  Host-side agent for the FIR shared sample memory. Streams input samples into memory port B,

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_mem_host_if.sv | 35 +++
 rtl/fir_mem_host_fifo2.sv | 64 ++++++
 rtl/fir_mem_host.sv | 159 +++++++++++++++
 tb/tb_fir_mem_host.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR host agent: default widths, run timeout and FSM encoding.
package fir_pkg;

   localparam int ADDR_W_DEF  = 10;
   localparam int DATA_W_DEF  = 8;
   localparam int TIMEOUT_DEF = 10000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_KICK,
      ST_WAIT,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } host_state_e;

   // 32-bit increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fir_mem_host_if.sv
// Sample stream, result stream, shared-memory ports and FIR handshake of the host agent.
interface fir_mem_host_if
   import fir_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              mem_we_b;
   logic [ADDR_W-1:0] mem_addr_b;
   logic [DATA_W-1:0] mem_data_in_b;
   logic [ADDR_W-1:0] mem_addr_a;
   logic [DATA_W-1:0] mem_data_out_a;
   logic              fir_start;
   logic              fir_done;

   // host agent view
   modport master (
      input  s_valid, s_data, m_ready, mem_data_out_a, fir_done,
      output s_ready, m_valid, m_data, mem_we_b, mem_addr_b, mem_data_in_b,
             mem_addr_a, fir_start
   );

   // environment view: sample source, result sink, memory and FIR
   modport slave (
      output s_valid, s_data, m_ready, mem_data_out_a, fir_done,
      input  s_ready, m_valid, m_data, mem_we_b, mem_addr_b, mem_data_in_b,
             mem_addr_a, fir_start
   );
endinterface

// File: rtl/fir_mem_host_fifo2.sv
// Two-entry valid/ready FIFO holding read results; entry 0 is always the head.
module fir_host_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   count
);
   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop, push_ok;

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = e0_q;
   assign count     = cnt_q;
   assign pop       = out_valid & out_ready;
   // a push into a full FIFO is only legal when the head leaves the same cycle
   assign push_ok   = push & ((cnt_q != 2'd2) | pop);

   // next entry contents and occupancy for push/pop combinations
   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      case ({push_ok, pop})
         2'b10: begin
            if (cnt_q == 2'd0) e0_d = push_data;
            else               e1_d = push_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               e0_d = push_data;
            end else begin
               e0_d = e1_q;
               e1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   // entry and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/fir_mem_host.sv
// Host agent for the FIR shared sample memory: loads samples through port B, kicks the FIR,
// times the run, then streams results read through registered port A.
module fir_mem_host
   import fir_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go,
   input  logic [ADDR_W-1:0] cfg_in_base,
   input  logic [ADDR_W-1:0] cfg_out_base,
   input  logic [ADDR_W-1:0] cfg_count,
   fir_mem_host_if.master    bus,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [31:0]       fir_cycles
);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   host_state_e       state_q, state_d;
   logic [ADDR_W-1:0] in_base_q, in_base_d;
   logic [ADDR_W-1:0] out_base_q, out_base_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              inflight_q, inflight_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic [31:0]       cyc_q, cyc_d;

   logic              fifo_valid;
   logic [DATA_W-1:0] fifo_data;
   logic [1:0]        fifo_cnt;
   logic              pop, wr, issue, last;
   logic [2:0]        occ;

   fir_host_fifo2 #(.W(DATA_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (bus.mem_data_out_a),
      .out_valid (fifo_valid),
      .out_ready (bus.m_ready),
      .out_data  (fifo_data),
      .count     (fifo_cnt)
   );

   assign pop   = fifo_valid & bus.m_ready;
   assign wr    = (state_q == ST_LOAD) & bus.s_valid;
   // occupancy counts the head leaving this cycle as already gone, so a held-ready sink
   // sees one result per cycle instead of one every other cycle
   assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue = (state_q == ST_READ) && (occ < 3'd2);
   // idx walks input slots in LOAD and output slots in READ; count is nonzero in both
   assign last  = (idx_q == count_q - ONE);

   assign bus.s_ready       = (state_q == ST_LOAD);
   assign bus.mem_we_b      = wr;
   assign bus.mem_addr_b    = in_base_q + idx_q;
   assign bus.mem_data_in_b = wr ? bus.s_data : '0;
   assign bus.mem_addr_a    = out_base_q + idx_q;
   assign bus.fir_start     = (state_q == ST_KICK);
   assign bus.m_valid       = fifo_valid;
   assign bus.m_data        = fifo_data;
   assign busy              = (state_q != ST_IDLE);
   assign done              = done_q;
   assign timeout_err       = timeout_q;
   assign fir_cycles        = cyc_q;

   // run sequencing: next state, run registers and status
   always_comb begin
      state_d    = state_q;
      in_base_d  = in_base_q;
      out_base_d = out_base_q;
      count_d    = count_q;
      idx_d      = idx_q;
      inflight_d = issue;
      done_d     = 1'b0;
      timeout_d  = timeout_q;
      cyc_d      = cyc_q;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               in_base_d  = cfg_in_base;
               out_base_d = cfg_out_base;
               count_d    = cfg_count;
               idx_d      = '0;
               timeout_d  = 1'b0;
               state_d    = (cfg_count == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (wr) begin
               idx_d = idx_q + ONE;
               if (last) begin
                  idx_d   = '0;
                  state_d = ST_KICK;
               end
            end
         end
         ST_KICK: begin
            cyc_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // the cycle that sees fir_done is still counted as part of the run
            cyc_d = sat_inc32(cyc_q);
            if (bus.fir_done) begin
               state_d = ST_READ;
            end else if (cyc_d == 32'(TIMEOUT)) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_READ: begin
            if (issue) begin
               idx_d = idx_q + ONE;
               if (last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!inflight_q && fifo_cnt == 2'd0) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and run registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         in_base_q  <= '0;
         out_base_q <= '0;
         count_q    <= '0;
         idx_q      <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         cyc_q      <= '0;
      end else begin
         state_q    <= state_d;
         in_base_q  <= in_base_d;
         out_base_q <= out_base_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         cyc_q      <= cyc_d;
      end
   end
endmodule

// File: tb/tb_fir_mem_host.sv
// Bench for fir_mem_host: behavioural memory + stub FIR (copies input+1), scoreboard queues
// for memory writes and results, fixed scenarios plus randomized jobs.
module tb_fir_mem_host;
   import fir_pkg::*;

   localparam int AW      = ADDR_W_DEF;
   localparam int DW      = DATA_W_DEF;
   localparam int TO      = 50;
   localparam int DEPTH   = 1 << AW;
   localparam int FIR_LAT = 7;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          go = 1'b0;
   logic [AW-1:0] cfg_in_base = '0;
   logic [AW-1:0] cfg_out_base = '0;
   logic [AW-1:0] cfg_count = '0;
   logic          busy, done, timeout_err;
   logic [31:0]   fir_cycles;

   int            n_tests = 0;
   int            n_fail = 0;
   wr_t           exp_wr[$];
   logic [DW-1:0] exp_res[$];
   logic [DW-1:0] samples[$];
   int            n_res = 0, n_start = 0, n_mv = 0, n_done = 0;
   int            ready_mode = 0;
   bit            fir_hang = 1'b0;
   int            job_in = 0, job_out = 0, job_cnt = 0;
   logic [DW-1:0] mem [DEPTH];
   int            fir_cnt = -1;
   bit            stall_prev = 1'b0;
   logic [DW-1:0] held = '0;
   logic [74:0]   outs;

   fir_mem_host_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   fir_mem_host #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .go           (go),
      .cfg_in_base  (cfg_in_base),
      .cfg_out_base (cfg_out_base),
      .cfg_count    (cfg_count),
      .bus          (bus.master),
      .busy         (busy),
      .done         (done),
      .timeout_err  (timeout_err),
      .fir_cycles   (fir_cycles)
   );

   always #5 clk = ~clk;

   assign outs = {busy, done, timeout_err, fir_cycles, bus.m_valid, bus.m_data, bus.s_ready,
                  bus.mem_we_b, bus.mem_addr_b, bus.mem_data_in_b, bus.mem_addr_a, bus.fir_start};

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // shared memory (port B write, registered port A read) and stub FIR
   always @(posedge clk) begin
      if (bus.mem_we_b) mem[bus.mem_addr_b] <= bus.mem_data_in_b;
      bus.mem_data_out_a <= mem[bus.mem_addr_a];
      if (!rst_n) begin
         fir_cnt      <= -1;
         bus.fir_done <= 1'b0;
      end else if (bus.fir_start) begin
         bus.fir_done <= 1'b0;
         fir_cnt      <= fir_hang ? -1 : FIR_LAT - 2;
      end else if (fir_cnt == 0) begin
         for (int i = 0; i < job_cnt; i++)
            mem[(job_out + i) % DEPTH] <= mem[(job_in + i) % DEPTH] + 8'd1;
         bus.fir_done <= 1'b1;
         fir_cnt      <= -1;
      end else if (fir_cnt > 0) begin
         fir_cnt <= fir_cnt - 1;
      end
   end

   // result sink ready pattern
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (bus.mem_we_b) begin
            chk("wr_expected", 128'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("wr_addr", bus.mem_addr_b, w.addr);
               chk("wr_data", bus.mem_data_in_b, w.data);
            end
         end
         if (stall_prev) begin
            chk("stall_valid", bus.m_valid, 1);
            chk("stall_data", bus.m_data, held);
         end
         if (bus.m_valid) n_mv++;
         if (bus.m_valid && bus.m_ready) begin
            chk("res_expected", 128'(exp_res.size() != 0), 1);
            if (exp_res.size() != 0) begin
               logic [DW-1:0] e;
               e = exp_res.pop_front();
               chk("m_data", bus.m_data, e);
            end
            n_res++;
         end
         stall_prev = bus.m_valid && !bus.m_ready;
         held       = bus.m_data;
         if (bus.fir_start) n_start++;
         if (done) n_done++;
      end
   end

   task automatic start_job(input int ib, input int ob, input bit hang);
      logic [DW-1:0] r;
      job_in   = ib;
      job_out  = ob;
      job_cnt  = samples.size();
      fir_hang = hang;
      for (int i = 0; i < samples.size(); i++) begin
         exp_wr.push_back('{addr: AW'((ib + i) % DEPTH), data: samples[i]});
         r = samples[i] + 8'd1;
         if (!hang) exp_res.push_back(r);
      end
      @(posedge clk);
      #1;
      go           = 1'b1;
      cfg_in_base  = AW'(ib);
      cfg_out_base = AW'(ob);
      cfg_count    = AW'(samples.size());
      @(posedge clk);
      #1;
      go = 1'b0;
   endtask

   task automatic feed(input bit gaps, output int cyc);
      int i = 0;
      cyc = 0;
      while (i < samples.size() && cyc < 5000) begin
         bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.s_data  = samples[i];
         @(negedge clk);
         if (bus.s_valid && bus.s_ready) i++;
         cyc++;
         @(posedge clk);
         #1;
      end
      bus.s_valid = 1'b0;
      chk("feed_all", i, samples.size());
   endtask

   task automatic wait_done(output int n);
      n = 1;
      while (n < 3000) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      chk("done_seen", 128'(n < 3000), 1);
   endtask

   task automatic run_job(input int ib, input int ob, input bit hang, input bit gaps,
                          output int fc, output int dc);
      int st0;
      int cnt;
      st0 = n_start;
      cnt = samples.size();
      start_job(ib, ob, hang);
      feed(gaps, fc);
      // junk traffic outside LOAD: sample offered and go pulsed while busy
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hA5;
      if (cnt != 0) begin
         go        = 1'b1;
         cfg_count = AW'(7);
         @(posedge clk);
         #1;
         go = 1'b0;
      end
      wait_done(dc);
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("done_width", done, 0);
      chk("fir_start_count", n_start - st0, (cnt == 0) ? 0 : 1);
      chk("timeout_err", timeout_err, hang);
      chk("writes_left", exp_wr.size(), 0);
      chk("results_left", exp_res.size(), 0);
   endtask

   initial begin
      int fc, dc, g, tgt, mv0, d0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", outs, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: sine samples, ready held
      samples    = '{8'd0, 8'd10, 8'd19, 8'd27, 8'd34};
      ready_mode = 0;
      run_job(0, 32, 1'b0, 1'b0, fc, dc);
      chk("t1_load_cycles", fc, 5);
      chk("t1_fir_cycles", fir_cycles, FIR_LAT);

      // 2: same with toggling ready
      ready_mode = 1;
      run_job(0, 32, 1'b0, 1'b0, fc, dc);
      chk("t2_fir_cycles", fir_cycles, FIR_LAT);
      ready_mode = 0;

      // 3: empty job
      samples.delete();
      run_job(0, 0, 1'b0, 1'b0, fc, dc);
      chk("t3_done_latency", dc, 2);

      // 4: FIR never finishes
      samples = '{8'd5, 8'd6, 8'd7};
      mv0 = n_mv;
      run_job(100, 200, 1'b1, 1'b0, fc, dc);
      chk("t4_fir_cycles", fir_cycles, TO);
      chk("t4_no_mvalid", n_mv - mv0, 0);

      // 5: reset during READ after two results
      samples.delete();
      for (int i = 0; i < 5; i++) samples.push_back(8'($urandom));
      start_job(300, 400, 1'b0);
      feed(1'b0, fc);
      tgt = n_res + 2;
      g   = 0;
      while (n_res < tgt && g < 500) begin
         @(posedge clk);
         g++;
      end
      chk("t5_two_results", 128'(n_res >= tgt), 1);
      #1 rst_n = 1'b0;
      exp_res.delete();
      exp_wr.delete();
      d0 = n_done;
      @(negedge clk);
      chk("t5_reset_outputs", outs, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_done", n_done - d0, 0);
      samples.delete();
      for (int i = 0; i < 3; i++) samples.push_back(8'($urandom));
      run_job(10, 20, 1'b0, 1'b0, fc, dc);
      chk("t5_after_timeout_clr", timeout_err, 0);

      // 6: input region wraps past the top of memory
      samples = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_job(1022, 500, 1'b0, 1'b0, fc, dc);

      // randomized jobs: random bases, lengths, source gaps and sink stalls
      for (int k = 0; k < 6; k++) begin
         int ib, ob, cnt;
         samples.delete();
         cnt = $urandom_range(1, 16);
         for (int i = 0; i < cnt; i++) samples.push_back(8'($urandom));
         ib         = $urandom_range(0, DEPTH - 1);
         ob         = $urandom_range(0, DEPTH - 1);
         ready_mode = $urandom_range(0, 2);
         run_job(ib, ob, 1'b0, 1'b1, fc, dc);
         chk("rand_fir_cycles", fir_cycles, FIR_LAT);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
